// File: rtl/result_buffer.sv
// result_buffer: ping-pong output buffer at the drain end of the systolic array.
// The array fills the write bank while the host drains the read bank.
// The drain sends each word low byte first over an 8-bit valid/ready port.
// A swap exchanges the two banks, but only once the read side is fully idle.
// Optional macro RESULT_BUF_SAT_EN saturates each word to signed 8 bits and
// emits one byte per word instead of two.
module result_buffer #(
  parameter int ACC_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ACC_W-1:0]         res_in,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     swap,
  output logic                     swap_done,
  output logic [7:0]               data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     read_empty,
  output logic [$clog2(DEPTH):0]   wr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

`ifdef RESULT_BUF_SAT_EN
  // One byte per word: the word is retired on the first byte's handshake.
  localparam state_t LAST_STATE = BYTE0;
`else
  localparam state_t LAST_STATE = BYTE1;
`endif

  // Both banks live in one array; the top address bit selects the bank.
  logic [ACC_W-1:0] mem [2*DEPTH];

  logic          active;       // bank currently written by the array
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_left;      // words still to be drained from the read bank
  logic [AW-1:0] rd_ptr;
  state_t        state;
  logic [7:0]    hi_byte_q;    // second byte of the word being sent
  logic [7:0]    data_q;
  logic          valid_q;
  logic          swap_done_q;

  logic          wr_fire;
  logic          swap_fire;
  logic          out_fire;
  logic          pop;
  logic [AW:0]   wr_addr;
  logic [AW:0]   rd_addr_cur;
  logic [AW:0]   rd_addr_nxt;
  logic [ACC_W-1:0] rd_word_cur;
  logic [ACC_W-1:0] rd_word_nxt;

  // Upper byte of the word, sign-extended from ACC_W to 16 bits.
  function automatic logic [7:0] upper_byte(input logic [ACC_W-1:0] w);
    logic [15:0] ext;
    ext = 16'($signed(w));
    return ext[15:8];
  endfunction

  // First (or only) byte sent for a word.
  function automatic logic [7:0] first_byte(input logic [ACC_W-1:0] w);
    logic signed [15:0] ext;
    logic [7:0]         b;
    ext = 16'($signed(w));
`ifdef RESULT_BUF_SAT_EN
    if (ext > 16'sd127)
      b = 8'h7F;
    else if (ext < -16'sd128)
      b = 8'h80;
    else
      b = ext[7:0];
`else
    b = ext[7:0];
`endif
    return b;
  endfunction

  // Handshake qualifiers and bank addressing.
  always_comb begin
    res_ready   = (wr_cnt < CW'(DEPTH));
    read_empty  = (rd_left == '0) && (state == IDLE);
    wr_fire     = res_valid && res_ready;
    swap_fire   = swap && read_empty;
    out_fire    = valid_q && out_ready;
    pop         = out_fire && (state == LAST_STATE);
    wr_addr     = {active, wr_cnt[AW-1:0]};
    rd_addr_cur = {~active, rd_ptr};
    rd_addr_nxt = {~active, rd_ptr + AW'(1)};
    rd_word_cur = mem[rd_addr_cur];
    rd_word_nxt = mem[rd_addr_nxt];
  end

  // Bank storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_addr] <= res_in;
  end

  // Bank control, swap handling and the output serializer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      wr_cnt      <= '0;
      rd_left     <= '0;
      rd_ptr      <= '0;
      state       <= IDLE;
      hi_byte_q   <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      swap_done_q <= swap_fire;

      // A write coinciding with the swap lands in the old bank and is counted.
      if (swap_fire) begin
        active  <= ~active;
        wr_cnt  <= '0;
        rd_left <= wr_cnt + CW'(wr_fire);
        rd_ptr  <= '0;
      end else if (wr_fire) begin
        wr_cnt <= wr_cnt + CW'(1);
      end

      // Swap is only accepted in IDLE with nothing left, so the read-side
      // updates below never collide with the swap updates above.
      case (state)
        IDLE: begin
          if (rd_left != '0) begin
            data_q    <= first_byte(rd_word_cur);
            hi_byte_q <= upper_byte(rd_word_cur);
            valid_q   <= 1'b1;
            state     <= BYTE0;
          end
        end
        BYTE0: begin
          if (out_fire && !pop) begin
            data_q <= hi_byte_q;
            state  <= BYTE1;
          end
        end
        BYTE1: ;
        default: state <= IDLE;
      endcase

      // Retire the current word; stream the next one without a bubble.
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_left <= rd_left - CW'(1);
        if (rd_left > CW'(1)) begin
          data_q    <= first_byte(rd_word_nxt);
          hi_byte_q <= upper_byte(rd_word_nxt);
          state     <= BYTE0;
        end else begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      end
    end
  end

  always_comb begin
    swap_done = swap_done_q;
    data_out  = data_q;
    out_valid = valid_q;
    wr_count  = wr_cnt;
  end

endmodule

// File: tb/tb_result_buffer.sv
// tb_result_buffer: directed and randomized checks of result_buffer against a
// queue-based reference model (write-bank words, pending output bytes).
module tb_result_buffer;

  localparam int ACC_W = 16;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst_n;
  logic [ACC_W-1:0] res_in;
  logic             res_valid;
  logic             res_ready;
  logic             swap;
  logic             swap_done;
  logic [7:0]       data_out;
  logic             out_valid;
  logic             out_ready;
  logic             read_empty;
  logic [$clog2(DEPTH):0] wr_count;

  result_buffer #(.ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_in     (res_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .swap       (swap),
    .swap_done  (swap_done),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .read_empty (read_empty),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [15:0] wr_q [$];   // words held in the write bank
  logic [7:0]  rd_q [$];   // bytes still to appear on data_out
  bit          warmup = 0;        // first cycle after a swap: no byte yet
  bit          exp_swap_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bytes a word turns into on the output port.
  task automatic push_word(input logic [15:0] w);
`ifdef RESULT_BUF_SAT_EN
    int v;
    v = int'($signed(w));
    if (v > 127) rd_q.push_back(8'h7F);
    else if (v < -128) rd_q.push_back(8'h80);
    else rd_q.push_back(w[7:0]);
`else
    rd_q.push_back(w[7:0]);
    rd_q.push_back(w[15:8]);
`endif
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic step(input logic rv, input logic [15:0] din, input logic sw, input logic ordy);
    bit exp_valid, wr_acc, sw_acc;
    res_valid = rv;
    res_in    = din;
    swap      = sw;
    out_ready = ordy;
    @(negedge clk);
    exp_valid = (rd_q.size() != 0) && !warmup;
    chk("swap_done",  swap_done,  exp_swap_done);
    chk("read_empty", read_empty, rd_q.size() == 0);
    chk("out_valid",  out_valid,  exp_valid);
    chk("res_ready",  res_ready,  wr_q.size() < DEPTH);
    chk("wr_count",   wr_count,   wr_q.size());
    if (exp_valid) begin
      chk("data_out", data_out, rd_q[0]);
      if (ordy) void'(rd_q.pop_front());
    end
    wr_acc = rv && (wr_q.size() < DEPTH);
    sw_acc = sw && (rd_q.size() == 0) && !warmup;
    warmup = 0;
    if (wr_acc) wr_q.push_back(din);
    if (sw_acc) begin
      foreach (wr_q[k]) push_word(wr_q[k]);
      wr_q.delete();
      warmup = (rd_q.size() != 0);
    end
    exp_swap_done = sw_acc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; res_valid = 1'b0; res_in = '0; swap = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_data_out",   data_out,   0);
    chk("rst_swap_done",  swap_done,  0);
    chk("rst_res_ready",  res_ready,  1);
    chk("rst_read_empty", read_empty, 1);
    chk("rst_wr_count",   wr_count,   0);
    rst_n = 1'b1;

    // Three words, swap, drain back-to-back.
    step(1, 16'h0102, 0, 1);
    step(1, 16'h0304, 0, 1);
    step(1, 16'hFF80, 0, 1);
    step(0, 16'h0000, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 16'h0000, 0, 1);

    // Swap of an empty write bank.
    step(0, 16'h0000, 1, 1);
    step(0, 16'h0000, 0, 1);

    // Fill past capacity with res_valid held high.
    for (int i = 0; i < 18; i++) step(1, 16'($urandom), 0, 1);

    // Swap, then keep swap asserted while draining and writing concurrently.
    step(0, 16'h0000, 1, 1);
    for (int i = 0; i < 45; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 45; i++) step(0, 16'h0000, 0, 1);
    step(0, 16'h0000, 1, 1);
    for (int i = 0; i < 45; i++) step(0, 16'h0000, 0, 1);

    // Stalls during the drain of 0xABCD.
    step(1, 16'hABCD, 0, 0);
    step(1, 16'hABCD, 1, 0);
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 1);
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 16'h0000, 0, 1);

    // Random traffic.
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) != 0));

    // Reset in the middle of a transfer discards everything.
    for (int i = 0; i < 5; i++) step(1, 16'($urandom), 0, 1);
    for (int i = 0; i < 5; i++) step(1, 16'($urandom), (i == 0), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out_valid",  out_valid,  0);
    chk("mid_rst_read_empty", read_empty, 1);
    chk("mid_rst_wr_count",   wr_count,   0);
    wr_q.delete();
    rd_q.delete();
    warmup = 0;
    exp_swap_done = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 16'h1234, 0, 1);
    step(0, 16'h0000, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 16'h0000, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
